// File: rtl/counter_share_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// counter_share_arbiter_pkg
// Shared definitions for the counter-sharing arbiter and its counter datapath.
//   state_e    : sequencer state encoding (IDLE, RUN, DONE)
//   *_RST      : values the sequencer registers take under reset
//   rr_next()  : advances a round-robin pointer by one, wrapping at n
// -----------------------------------------------------------------------------
package counter_share_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_e;

  localparam state_e STATE_RST = IDLE;
  localparam int     RR_RST    = 0;
  localparam int     OWNER_RST = 0;

  // Step the pointer past the given index, wrapping n-1 back to 0.
  function automatic int rr_next(input int ptr, input int n);
    if (ptr + 1 >= n) begin
      return 0;
    end
    return ptr + 1;
  endfunction

endpackage

// File: rtl/load_down_counter.sv
// -----------------------------------------------------------------------------
// load_down_counter
// Loadable binary down-counter that saturates at zero.
// Ports:
//   clk      : clock, rising edge
//   res      : synchronous active-high reset, clears the count
//   load     : load load_val on the next edge (beats dec)
//   load_val : value to load
//   dec      : decrement on the next edge when the count is non-zero
//   cnt      : current count
//   zero     : high while the count is zero
// -----------------------------------------------------------------------------
module load_down_counter
  import counter_share_arbiter_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         res,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] cnt,
  output logic         zero
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: a load overrides everything, and a decrement is refused at
  // zero so the count can never wrap to all ones.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Count register, cleared by the synchronous reset.
  always_ff @(posedge clk) begin
    if (res) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt  = cnt_q;
  assign zero = (cnt_q == '0);

endmodule

// File: rtl/counter_share_arbiter.sv
// -----------------------------------------------------------------------------
// counter_share_arbiter
// Shares one interval down-counter among N requesters using round-robin
// arbitration. The winner's length is loaded, counted down to zero and a
// one-cycle done pulse reports which requester finished. Dropping a request
// while it owns the counter aborts the interval without a done pulse.
// Ports:
//   clk     : clock, rising edge
//   res     : synchronous active-high reset
//   req     : per-requester request levels
//   len     : flattened interval lengths, requester i at len[i*W +: W]
//   grant   : one-hot owner indication while an interval runs
//   busy    : high in RUN or DONE
//   cnt     : current counter value (debug)
//   done    : one-cycle completion pulse
//   done_id : index of the completed requester, valid with done
// -----------------------------------------------------------------------------
module counter_share_arbiter
  import counter_share_arbiter_pkg::*;
#(
  parameter int N   = 4,
  parameter int W   = 8,
  parameter int IDW = $clog2(N)
) (
  input  logic           clk,
  input  logic           res,
  input  logic [N-1:0]   req,
  input  logic [N*W-1:0] len,
  output logic [N-1:0]   grant,
  output logic           busy,
  output logic [W-1:0]   cnt,
  output logic           done,
  output logic [IDW-1:0] done_id
);

  localparam logic [N-1:0] GRANT_ONE = {{(N-1){1'b0}}, 1'b1};

  state_e         state_q;
  logic [IDW-1:0] owner_q;
  logic [IDW-1:0] rrPtr_q;
  logic [N-1:0]   grant_q;
  logic           done_q;
  logic [IDW-1:0] doneId_q;

  logic           winnerValid;
  logic [IDW-1:0] winnerIdx;
  logic [W-1:0]   loadVal;
  logic           cntLoad;
  logic           cntDec;
  logic           cntZero;
  logic [W-1:0]   cntVal;

  // Round-robin pick: scan upward from the pointer, wrapping at N, and take
  // the first requester that is asking.
  always_comb begin
    int j;
    logic [IDW-1:0] cand;
    winnerValid = 1'b0;
    winnerIdx   = '0;
    j           = 0;
    cand        = '0;
    for (int k = 0; k < N; k++) begin
      j = int'(rrPtr_q) + k;
      if (j >= N) begin
        j = j - N;
      end
      cand = IDW'(j);
      if (!winnerValid && req[cand]) begin
        winnerValid = 1'b1;
        winnerIdx   = cand;
      end
    end
  end

  // Select the winner's interval length with constant slices only.
  always_comb begin
    loadVal = '0;
    for (int i = 0; i < N; i++) begin
      if (IDW'(i) == winnerIdx) begin
        loadVal = len[i*W +: W];
      end
    end
  end

  // The counter loads at the grant edge and only counts while the owner
  // still requests; on an abort it simply holds its last value.
  assign cntLoad = (state_q == IDLE) && winnerValid;
  assign cntDec  = (state_q == RUN) && req[owner_q] && !cntZero;

  load_down_counter #(
    .W(W)
  ) uCounter (
    .clk      (clk),
    .res      (res),
    .load     (cntLoad),
    .load_val (loadVal),
    .dec      (cntDec),
    .cnt      (cntVal),
    .zero     (cntZero)
  );

  // Sequencer with registered outputs. In RUN the abort check comes before
  // the terminal-count check, so a request dropped on the last cycle never
  // produces a done pulse. Both exits move the pointer past the owner.
  always_ff @(posedge clk) begin
    if (res) begin
      state_q  <= STATE_RST;
      owner_q  <= IDW'(OWNER_RST);
      rrPtr_q  <= IDW'(RR_RST);
      grant_q  <= '0;
      done_q   <= 1'b0;
      doneId_q <= IDW'(OWNER_RST);
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (winnerValid) begin
            owner_q <= winnerIdx;
            grant_q <= GRANT_ONE << winnerIdx;
            state_q <= RUN;
          end
        end
        RUN: begin
          if (!req[owner_q]) begin
            grant_q <= '0;
            rrPtr_q <= IDW'(rr_next(int'(owner_q), N));
            state_q <= IDLE;
          end else if (cntZero) begin
            grant_q  <= '0;
            done_q   <= 1'b1;
            doneId_q <= owner_q;
            rrPtr_q  <= IDW'(rr_next(int'(owner_q), N));
            state_q  <= DONE;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          grant_q <= '0;
          state_q <= STATE_RST;
        end
      endcase
    end
  end

  assign grant   = grant_q;
  assign busy    = (state_q == RUN) || (state_q == DONE);
  assign cnt     = cntVal;
  assign done    = done_q;
  assign done_id = doneId_q;

endmodule
